lc3b_mem_port_arbiter: RTL
==========================

// Module: lc3b_mem_port_arbiter
// PURPOSE
//  Shares one single-ported, variable-latency memory between instruction fetch (ICACHE side, read-only)
//  and the MEM stage (D-side, read/write). Generates the ICACHE.R (imem_r) and DCACHE.R (dmem_r) ready
//  pulses that the fetch and MEM stages consume for their stall logic.
//  Squashes stale fetch responses after a PC redirect so a wrong-path instruction never reaches DE.
// PARAMETERS
//  AW            16  address width (byte address)
//  DW            16  data width (one LC-3b word)
//  IF_STARVE_MAX  4  max consecutive MEM grants while IF is pending; the next grant is then forced to IF
// PORTS
//  clk           in   1   clock; all state updates on posedge
//  rst           in   1   synchronous reset, active-high
//  if_req        in   1   fetch request; held high until imem_r or PC change
//  if_addr       in   AW  fetch address (current PC)
//  imem_r        out  1   fetch data valid this cycle (ICACHE.R)
//  instr         out  DW  fetched instruction; valid when imem_r=1
//  mem_req       in   1   MEM-stage request; held high with stable fields until dmem_r
//  mem_addr      in   AW  data address
//  mem_we        in   2   byte write enables {hi,lo}; 00 = read
//  mem_wdata     in   DW  store data
//  dmem_r        out  1   data access complete this cycle (DCACHE.R)
//  dmem_rdata    out  DW  load data; valid when dmem_r=1
//  m_en          out  1   backing-memory access enable
//  m_we          out  2   backing-memory byte write enables
//  m_addr        out  AW  backing-memory address
//  m_wdata       out  DW  backing-memory write data
//  m_ready       in   1   backing memory completes the access this cycle; m_rdata is valid
//  m_rdata       in   DW  backing-memory read data
// BEHAVIOUR
//  - Reset values: state=IDLE, all outputs 0 (m_en, m_we, m_addr, m_wdata, imem_r, dmem_r, instr, dmem_rdata), starve_cnt=0.
//  - FSM states: IDLE, IF_BUSY, MEM_BUSY, RESP. All m_* outputs are registered.
//  - IDLE
//    - mem_req=1 and (if_req=0 or starve_cnt<IF_STARVE_MAX): latch mem fields, go to MEM_BUSY.
//      If if_req=1, starve_cnt++ (saturating).
//    - Else if if_req=1: latch if_addr into if_addr_q, go to IF_BUSY, starve_cnt=0.
//    - Else: remain in IDLE.
//  - IF_BUSY / MEM_BUSY: m_en=1 with the latched fields, held stable. IF_BUSY drives m_we=00.
//    - On m_ready=1: capture m_rdata and the source tag, go to RESP.
//  - RESP lasts exactly one cycle, then IDLE. Requests are NOT sampled in RESP, so a requester still
//    high on its ready pulse cycle never issues a duplicate access. m_en=0 in RESP.
//  - dmem_r = (state==RESP) & tag==MEM. dmem_rdata = the captured data (write: the data is don't-care but is driven).
//  - imem_r = (state==RESP) & tag==IF & if_req & (if_addr==if_addr_q).
//    - If the compare fails (redirect or stall changed the PC), the response is squashed silently: imem_r=0.
//      The fetch re-requests on a later IDLE.
//  - instr = the captured data whenever tag==IF, else 0. This forms the bubble path with imem_r=0.
//  - Latency: request seen in IDLE (cycle 0); m_en from cycle 1; m_ready at cycle k>=1; ready pulse at cycle k+1; IDLE at k+2.
//    Minimum request-to-ready is 2 cycles.
//  - A request dropped while BUSY does not abort the memory access. The access completes and the result is
//    discarded: imem_r via the compare; dmem_r still pulses, and MEM ignores it.
//  - mem_req and if_req both high in IDLE: MEM wins, unless starve_cnt==IF_STARVE_MAX. In that case IF wins and starve_cnt clears.
//  - rst asserted mid-access: FSM returns to IDLE next edge and m_en drops. The in-flight result is never reported.
//    The backing memory must also be reset.
//  - No address arithmetic. The full AW-bit address is passed through; the word/byte selection belongs to the memory.
// STRUCTURE
//  - Package lc3b_mem_pkg: typedef enum logic [1:0] {IDLE, IF_BUSY, MEM_BUSY, RESP} arb_state_t;
//    typedef enum logic {SRC_IF, SRC_MEM} arb_src_t; constants WE_NONE=2'b00, WE_WORD=2'b11.
//  - Single module: the FSM, the request latches, and the saturating starve counter are all inline. No sub-module.
// TESTING (memory model: m_ready asserted N cycles after m_en rises, N configurable)
//  1. IF only: if_addr=3000, memory word 1234, N=1 -> imem_r pulses once at cycle 2 with instr=1234; m_we=00 throughout.
//  2. MEM store: mem_addr=4000, mem_we=11, wdata=BEEF, N=3 -> m_en held cycles 1-3 with stable fields; dmem_r at cycle 4;
//     a read of 4000 then returns BEEF.
//  3. Collision: if_req and mem_req both high in IDLE -> MEM is served first, then IF.
//     If mem_req is re-asserted continuously, IF is forced after exactly 4 MEM grants.
//  4. Redirect squash: IF request to 3002 with N=4; if_addr changes to 4ABC at cycle 2 -> no imem_r for 3002;
//     the next access is to 4ABC and imem_r returns its data.
//  5. Held request: mem_req kept high through its RESP cycle -> exactly one m_en burst; no duplicate access.
//  6. Reset mid-access: rst at cycle 2 of an N=5 read -> m_en=0, imem_r=0, dmem_r=0 on the next cycle; state=IDLE; no ready pulse follows.

Source files
------------

// File: rtl/lc3b_mem_pkg.sv
// Shared types and constants for the LC-3b memory-port arbiter.
package lc3b_mem_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      IF_BUSY  = 2'd1,
      MEM_BUSY = 2'd2,
      RESP     = 2'd3
   } arb_state_t;

   typedef enum logic {
      SRC_IF  = 1'b0,
      SRC_MEM = 1'b1
   } arb_src_t;

   localparam logic [1:0] WE_NONE = 2'b00;
   localparam logic [1:0] WE_WORD = 2'b11;

endpackage

// File: rtl/lc3b_mem_port_arbiter.sv
// Arbitrates one variable-latency memory port between instruction fetch and the MEM stage,
// producing the ICACHE.R / DCACHE.R ready pulses and squashing fetches made stale by a redirect.
module lc3b_mem_port_arbiter
   import lc3b_mem_pkg::*;
#(
   parameter int AW            = 16,
   parameter int DW            = 16,
   parameter int IF_STARVE_MAX = 4
) (
   input  logic          clk,
   input  logic          rst,
   // fetch side
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic          imem_r,
   output logic [DW-1:0] instr,
   // MEM-stage side
   input  logic          mem_req,
   input  logic [AW-1:0] mem_addr,
   input  logic [1:0]    mem_we,
   input  logic [DW-1:0] mem_wdata,
   output logic          dmem_r,
   output logic [DW-1:0] dmem_rdata,
   // backing memory
   output logic          m_en,
   output logic [1:0]    m_we,
   output logic [AW-1:0] m_addr,
   output logic [DW-1:0] m_wdata,
   input  logic          m_ready,
   input  logic [DW-1:0] m_rdata
);

   localparam int            SW           = $clog2(IF_STARVE_MAX + 1);
   localparam logic [SW-1:0] STARVE_LIMIT = SW'(IF_STARVE_MAX);

   arb_state_t    state_reg, state_next;
   arb_src_t      tag_reg, tag_next;
   logic [SW-1:0] starve_reg, starve_next;
   logic [DW-1:0] data_reg, data_next;
   logic [AW-1:0] if_addr_q_reg, if_addr_q_next;

   logic          m_en_reg, m_en_next;
   logic [1:0]    m_we_reg, m_we_next;
   logic [AW-1:0] m_addr_reg, m_addr_next;
   logic [DW-1:0] m_wdata_reg, m_wdata_next;

   logic          mem_wins;
   logic          starve_room;

   assign starve_room = (starve_reg < STARVE_LIMIT);
   // MEM normally has priority; IF takes the port once MEM has starved it long enough.
   assign mem_wins    = mem_req && (!if_req || starve_room);

   always_comb begin
      state_next     = state_reg;
      tag_next       = tag_reg;
      starve_next    = starve_reg;
      data_next      = data_reg;
      if_addr_q_next = if_addr_q_reg;
      m_en_next      = m_en_reg;
      m_we_next      = m_we_reg;
      m_addr_next    = m_addr_reg;
      m_wdata_next   = m_wdata_reg;

      case (state_reg)
         IDLE: begin
            m_en_next = 1'b0;
            m_we_next = WE_NONE;
            if (mem_wins) begin
               state_next   = MEM_BUSY;
               m_en_next    = 1'b1;
               m_we_next    = mem_we;
               m_addr_next  = mem_addr;
               m_wdata_next = mem_wdata;
               if (if_req)
                  starve_next = starve_reg + SW'(1);
            end else if (if_req) begin
               state_next     = IF_BUSY;
               m_en_next      = 1'b1;
               m_we_next      = WE_NONE;
               m_addr_next    = if_addr;
               if_addr_q_next = if_addr;
               starve_next    = '0;
            end
         end

         IF_BUSY, MEM_BUSY: begin
            // The access runs to completion even if its requester has gone away.
            if (m_ready) begin
               state_next = RESP;
               m_en_next  = 1'b0;
               m_we_next  = WE_NONE;
               data_next  = m_rdata;
               tag_next   = (state_reg == IF_BUSY) ? SRC_IF : SRC_MEM;
            end
         end

         RESP: begin
            // Requests are deliberately ignored here so a held request is not re-issued.
            state_next = IDLE;
            m_en_next  = 1'b0;
            m_we_next  = WE_NONE;
         end

         default: begin
            state_next = IDLE;
            m_en_next  = 1'b0;
            m_we_next  = WE_NONE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         tag_reg       <= SRC_IF;
         starve_reg    <= '0;
         data_reg      <= '0;
         if_addr_q_reg <= '0;
         m_en_reg      <= 1'b0;
         m_we_reg      <= WE_NONE;
         m_addr_reg    <= '0;
         m_wdata_reg   <= '0;
      end else begin
         state_reg     <= state_next;
         tag_reg       <= tag_next;
         starve_reg    <= starve_next;
         data_reg      <= data_next;
         if_addr_q_reg <= if_addr_q_next;
         m_en_reg      <= m_en_next;
         m_we_reg      <= m_we_next;
         m_addr_reg    <= m_addr_next;
         m_wdata_reg   <= m_wdata_next;
      end
   end

   assign m_en    = m_en_reg;
   assign m_we    = m_we_reg;
   assign m_addr  = m_addr_reg;
   assign m_wdata = m_wdata_reg;

   // A fetch response is only delivered if the PC still matches what was fetched.
   assign imem_r     = (state_reg == RESP) && (tag_reg == SRC_IF) && if_req && (if_addr == if_addr_q_reg);
   assign dmem_r     = (state_reg == RESP) && (tag_reg == SRC_MEM);
   assign instr      = (tag_reg == SRC_IF) ? data_reg : '0;
   assign dmem_rdata = data_reg;

endmodule
